// File: rtl/operand_fetch_if.sv
// Request, writeback and operand handshake bundle between the operand-fetch stage and its neighbours.
interface operand_fetch_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] rn_addr;
    logic [ADDR_W-1:0] rm_addr;
    logic [1:0]        shift_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [1:0]        shift_out;

    modport slave (
        input  req_valid, rn_addr, rm_addr, shift_in,
        input  wr_en, wr_addr, wr_data,
        input  op_ready,
        output req_ready, op_valid, a_out, b_out, shift_out
    );

    modport master (
        output req_valid, rn_addr, rm_addr, shift_in,
        output wr_en, wr_addr, wr_data,
        output op_ready,
        input  req_ready, op_valid, a_out, b_out, shift_out
    );
endinterface

// File: rtl/operand_fetch.sv
// Register file plus two-cycle operand fetch (Rn -> A, then Rm -> B) feeding the shifter/ALU
// through a valid/ready handshake.
module operand_fetch #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic [ADDR_W-1:0] rn_q;
    logic [ADDR_W-1:0] rm_q;
    logic [1:0]        sh_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rf [NREGS];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, accept decode and shared read port with write-through forwarding
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rd_addr    = rm_q;
        case (state)
            IDLE: begin
                accept = bus.req_valid && bus.req_ready;
                if (accept) next_state = READ_A;
            end
            READ_A: begin
                rd_addr    = rn_q;
                next_state = READ_B;
            end
            READ_B: next_state = HOLD;
            HOLD:   if (bus.op_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.wr_en && (bus.wr_addr == rd_addr)) begin
            rd_data = bus.wr_data;
        end else begin
            rd_data = rf[rd_addr];
        end
    end

    // Register file write port, active in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
        end else if (bus.wr_en) begin
            rf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Request capture, operand registers and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rn_q          <= '0;
            rm_q          <= '0;
            sh_q          <= '0;
            bus.a_out     <= '0;
            bus.b_out     <= '0;
            bus.shift_out <= '0;
            bus.req_ready <= 1'b0;
            bus.op_valid  <= 1'b0;
        end else begin
            if (accept) begin
                rn_q <= bus.rn_addr;
                rm_q <= bus.rm_addr;
                sh_q <= bus.shift_in;
            end
            if (state == READ_A) bus.a_out <= rd_data;
            if (state == READ_B) begin
                bus.b_out     <= rd_data;
                bus.shift_out <= sh_q;
            end
            // Flags follow the state being entered so they line up with it
            bus.req_ready <= (next_state == IDLE);
            bus.op_valid  <= (next_state == HOLD);
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: register-file model, expected-operand queue and immediate assertions.
module tb_operand_fetch;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sh;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [15:0] rf_model [8];

    operand_fetch_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    operand_fetch #(.DATA_W(16), .NREGS(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] shifter(input logic [15:0] d, input logic [1:0] sh);
        case (sh)
            2'b01:   return {d[14:0], 1'b0};
            2'b10:   return {1'b0, d[15:1]};
            2'b11:   return {d[15], d[15:1]};
            default: return d;
        endcase
    endfunction

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
        rf_model[addr] = data;
    endtask

    // Waits for req_ready, then presents one request for exactly one accepting edge
    task automatic do_req(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh);
        for (int i = 0; i < 10 && bus.req_ready !== 1'b1; i++) step();
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.rn_addr   = rn;
        bus.rm_addr   = rm;
        bus.shift_in  = sh;
        step();
        bus.req_valid = 1'b0;
        bus.rn_addr   = 3'($urandom);
        bus.rm_addr   = 3'($urandom);
        bus.shift_in  = 2'($urandom);
    endtask

    // Waits for op_valid, compares against the queue head, then completes the handshake
    task automatic expect_op(input string tag);
        exp_t e;
        for (int i = 0; i < 10 && bus.op_valid !== 1'b1; i++) step();
        chk({tag, "_valid"}, 32'(bus.op_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_a"}, 32'(bus.a_out), 32'(e.a));
            chk({tag, "_b"}, 32'(bus.b_out), 32'(e.b));
            chk({tag, "_sh"}, 32'(bus.shift_out), 32'(e.sh));
        end
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.op_valid), 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            do_req(3'(2 * i), 3'(2 * i + 1), 2'(i));
            sb.push_back('{a: rf_model[2 * i], b: rf_model[2 * i + 1], sh: 2'(i)});
            expect_op(tag);
        end
    endtask

    initial begin
        exp_t e;
        int   acc;
        int   k;
        int   npulse;
        int   last;
        logic prev;
        logic [2:0] rn_t [3];
        logic [2:0] rm_t [3];
        logic [1:0] sh_t [3];

        foreach (rf_model[i]) rf_model[i] = 16'h0000;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rn_addr   = '0;
        bus.rm_addr   = '0;
        bus.shift_in  = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.op_ready  = 1'b0;

        // Reset
        repeat (3) step();
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_a", 32'(bus.a_out), 32'd0);
        chk("rst_b", 32'(bus.b_out), 32'd0);
        chk("rst_sh", 32'(bus.shift_out), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
        read_all("zero_rd");

        // Basic fetch with latency checks
        wr(3'd2, 16'h1234);
        wr(3'd5, 16'h8001);
        do_req(3'd2, 3'd5, 2'b11);
        sb.push_back('{a: 16'h1234, b: 16'h8001, sh: 2'b11});
        chk("e0_op_valid", 32'(bus.op_valid), 32'd0);
        step();
        chk("e1_a", 32'(bus.a_out), 32'h1234);
        chk("e1_op_valid", 32'(bus.op_valid), 32'd0);
        step();
        chk("e2_b", 32'(bus.b_out), 32'h8001);
        chk("e2_sh", 32'(bus.shift_out), 32'd3);
        chk("e2_op_valid", 32'(bus.op_valid), 32'd1);
        chk("sout", 32'(shifter(bus.b_out, bus.shift_out)), 32'hC000);

        // Backpressure: operands frozen, register writes and new requests do not disturb them
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.rn_addr   = 3'd0;
            bus.rm_addr   = 3'd1;
            wr(3'd5, 16'hFFFF);
            chk("bp_b", 32'(bus.b_out), 32'h8001);
            chk("bp_valid", 32'(bus.op_valid), 32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        expect_op("bp");
        chk("bp_idle_ready", 32'(bus.req_ready), 32'd1);
        step();
        chk("bp_no_extra", 32'(bus.op_valid), 32'd0);

        // Forwarding on the READ_A edge, and on the READ_B edge
        wr(3'd3, 16'h0001);
        do_req(3'd3, 3'd3, 2'b01);
        sb.push_back('{a: 16'hABCD, b: 16'hABCD, sh: 2'b01});
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'hABCD;
        step();
        bus.wr_en = 1'b0;
        rf_model[3] = 16'hABCD;
        chk("fwd_a", 32'(bus.a_out), 32'hABCD);
        expect_op("fwd_a");
        do_req(3'd3, 3'd4, 2'b10);
        sb.push_back('{a: 16'hABCD, b: 16'h5A5A, sh: 2'b10});
        step();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'h5A5A;
        step();
        bus.wr_en = 1'b0;
        rf_model[4] = 16'h5A5A;
        expect_op("fwd_b");

        // Reset while in READ_B
        wr(3'd1, 16'h7777);
        do_req(3'd1, 3'd1, 2'b10);
        step();
        chk("mid_a_loaded", 32'(bus.a_out), 32'h7777);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.op_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_a", 32'(bus.a_out), 32'd0);
        foreach (rf_model[i]) rf_model[i] = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("mid_rst_hold", 32'(bus.op_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_pulse", 32'(bus.op_valid), 32'd0);
        end
        read_all("post_rst_rd");

        // Back-to-back requests with op_ready held high
        wr(3'd6, 16'h0606);
        wr(3'd7, 16'h0707);
        wr(3'd0, 16'h0A0A);
        rn_t[0] = 3'd6; rm_t[0] = 3'd7; sh_t[0] = 2'd1;
        rn_t[1] = 3'd7; rm_t[1] = 3'd0; sh_t[1] = 2'd2;
        rn_t[2] = 3'd0; rm_t[2] = 3'd6; sh_t[2] = 2'd0;
        k = 0; npulse = 0; last = 0; prev = 1'b0;
        bus.rn_addr = rn_t[0]; bus.rm_addr = rm_t[0]; bus.shift_in = sh_t[0];
        bus.req_valid = 1'b1;
        bus.op_ready  = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            acc = (bus.req_ready === 1'b1 && bus.req_valid === 1'b1) ? 1 : 0;
            step();
            if (acc != 0) begin
                sb.push_back('{a: rf_model[rn_t[k]], b: rf_model[rm_t[k]], sh: sh_t[k]});
                k++;
                if (k == 3) begin
                    bus.req_valid = 1'b0;
                end else begin
                    bus.rn_addr = rn_t[k]; bus.rm_addr = rm_t[k]; bus.shift_in = sh_t[k];
                end
            end
            if (prev) chk("b2b_single_pulse", 32'(bus.op_valid), 32'd0);
            if (bus.op_valid === 1'b1) begin
                if (npulse > 0) chk("b2b_gap", 32'(cyc - last), 32'd4);
                if (sb.size() == 0) begin
                    chk("b2b_sb_empty", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("b2b_a", 32'(bus.a_out), 32'(e.a));
                    chk("b2b_b", 32'(bus.b_out), 32'(e.b));
                    chk("b2b_sh", 32'(bus.shift_out), 32'(e.sh));
                end
                last = cyc;
                npulse++;
            end
            prev = bus.op_valid;
        end
        bus.op_ready = 1'b0;
        chk("b2b_count", 32'(npulse), 32'd3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
